// File: rtl/attack_sequencer_pkg.sv
// Shared encodings and constants for the attack sequencer.
package attack_sequencer_pkg;

  typedef enum logic [1:0] {
    PH_IDLE    = 2'd0,
    PH_WINDUP  = 2'd1,
    PH_ACTIVE  = 2'd2,
    PH_RECOVER = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    ST_LAUNCH = 2'd0,
    ST_ACK    = 2'd1,
    ST_RUN    = 2'd2
  } step_e;

  localparam int unsigned ACK_TIMEOUT = 4;
  localparam int unsigned ACK_CNT_W   = 2;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector; history resets high so a level held through reset is not an event.
module edge_detect_rise (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev_q <= 1'b1;
    else        prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/attack_sequencer.sv
// Attack phase sequencer driving a fraction-second timer: WINDUP -> ACTIVE -> RECOVER.
// Define ATTACK_COMBO_EN to let presses during ACTIVE chain further ACTIVE phases.
module attack_sequencer
  import attack_sequencer_pkg::*;
#(
  parameter int unsigned WINDUP_FRAC  = 4,
  parameter int unsigned ACTIVE_FRAC  = 6,
  parameter int unsigned RECOVER_FRAC = 3,
  parameter int unsigned MAX_COMBO    = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       attack_req,
  output logic       tmr_start,
  output logic [3:0] tmr_fraction,
  input  logic       tmr_running,
  input  logic       tmr_done,
  input  logic       tmr_halfway,
  output logic [1:0] phase,
  output logic       hitbox_en,
  output logic       busy,
  output logic [3:0] combo_depth,
  output logic [7:0] attack_count
);

  phase_e               phase_q, phase_d;
  step_e                step_q, step_d;
  logic [ACK_CNT_W-1:0] ack_cnt_q, ack_cnt_d;
  logic                 hit_q, hit_d;
  logic [3:0]           combo_q, combo_d;
  logic [7:0]           cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 rise;
  logic                 pend_set;
  logic                 combo_go;

  edge_detect_rise u_edge (
    .clk    (clk),
    .rst_n  (reset),
    .d_i    (attack_req),
    .rise_o (rise)
  );

`ifdef ATTACK_COMBO_EN
  assign pend_set = (phase_q == PH_ACTIVE) && rise;
`else
  assign pend_set = 1'b0;
`endif
  // With combos disabled pend_q never sets, so combo_go stays low.
  assign combo_go = pend_q && (combo_q < 4'(MAX_COMBO));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= PH_IDLE;
      step_q    <= ST_LAUNCH;
      ack_cnt_q <= '0;
      hit_q     <= 1'b0;
      combo_q   <= '0;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      step_q    <= step_d;
      ack_cnt_q <= ack_cnt_d;
      hit_q     <= hit_d;
      combo_q   <= combo_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    step_d    = step_q;
    ack_cnt_d = ack_cnt_q;
    hit_d     = hit_q;
    combo_d   = combo_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    tmr_start = 1'b0;

    if (pend_set) pend_d = 1'b1;

    if (phase_q == PH_IDLE) begin
      if (rise) begin
        phase_d = PH_WINDUP;
        step_d  = ST_LAUNCH;
      end
    end else begin
      unique case (step_q)
        ST_LAUNCH: begin
          if (!tmr_running) begin
            tmr_start = 1'b1;
            step_d    = ST_ACK;
            ack_cnt_d = '0;
          end
        end
        ST_ACK: begin
          if (tmr_running) begin
            step_d = ST_RUN;
          end else if (ack_cnt_q == ACK_CNT_W'(ACK_TIMEOUT - 1)) begin
            // Timer never acknowledged: pulse start again.
            step_d    = ST_LAUNCH;
            ack_cnt_d = '0;
          end else begin
            ack_cnt_d = ack_cnt_q + 1'b1;
          end
        end
        ST_RUN: begin
          if (phase_q == PH_ACTIVE && tmr_halfway) hit_d = 1'b1;
          if (tmr_done) begin
            step_d = ST_LAUNCH;
            hit_d  = 1'b0;
            unique case (phase_q)
              PH_WINDUP: begin
                phase_d = PH_ACTIVE;
                combo_d = combo_q + 4'd1;
                pend_d  = 1'b0;
              end
              PH_ACTIVE: begin
                if (combo_go) begin
                  combo_d = combo_q + 4'd1;
                  pend_d  = 1'b0;
                end else begin
                  phase_d = PH_RECOVER;
                end
              end
              default: begin
                phase_d = PH_IDLE;
                combo_d = '0;
                pend_d  = 1'b0;
                cnt_d   = sat_inc8(cnt_q);
              end
            endcase
          end
        end
        default: step_d = ST_LAUNCH;
      endcase
    end
  end

  always_comb begin
    unique case (phase_q)
      PH_WINDUP:  tmr_fraction = 4'(WINDUP_FRAC);
      PH_ACTIVE:  tmr_fraction = 4'(ACTIVE_FRAC);
      PH_RECOVER: tmr_fraction = 4'(RECOVER_FRAC);
      default:    tmr_fraction = 4'd0;
    endcase
  end

  assign phase        = phase_q;
  assign busy         = (phase_q != PH_IDLE);
  assign hitbox_en    = hit_q;
  assign combo_depth  = combo_q;
  assign attack_count = cnt_q;

endmodule

// File: doc/attack_sequencer.md
ATTACK_SEQUENCER -- requirements
Module: attack_sequencer

Interface
REQ-001 The block SHALL be parameterised: WINDUP_FRAC, 4, timer fraction for wind-up phase.
REQ-002 The block SHALL be parameterised: ACTIVE_FRAC, 6, timer fraction for hit-active phase.
REQ-003 The block SHALL be parameterised: RECOVER_FRAC, 3, timer fraction for recovery phase.
REQ-004 The block SHALL be parameterised: MAX_COMBO, 3, maximum chained ACTIVE phases per attack (1..15).
REQ-005 Ports SHALL be: clk  in  1  system clock, single clock domain.
REQ-006 Ports SHALL be: reset  in  1  asynchronous, active-low reset.
REQ-007 Ports SHALL be: attack_req  in  1  player button level, already synchronised.
REQ-008 Ports SHALL be: tmr_start  out  1  one-cycle start pulse to the fraction-second timer.
REQ-009 Ports SHALL be: tmr_fraction  out  4  fraction denominator driven to the timer.
REQ-010 Ports SHALL be: tmr_running, tmr_done, tmr_halfway  in  1 each  timer status/pulses.
REQ-011 Ports SHALL be: phase  out  2  0 IDLE, 1 WINDUP, 2 ACTIVE, 3 RECOVER.
REQ-012 Ports SHALL be: hitbox_en  out  1  damage window; busy  out  1  phase != IDLE.
REQ-013 Ports SHALL be: combo_depth  out  4  ACTIVE phases entered in current attack.
REQ-014 Ports SHALL be: attack_count  out  8  completed attacks, saturating at 255.

Function
REQ-015 attack_req SHALL be edge-detected internally; only a 0->1 transition is an event.
REQ-016 Each phase SHALL run sub-steps LAUNCH -> ACK -> RUN; LAUNCH drives tmr_start=1 for exactly one cycle and only when tmr_running=0, else waits in LAUNCH.
REQ-017 tmr_fraction SHALL be held at the current phase's parameter from LAUNCH through RUN; 0 in IDLE.
REQ-018 ACK SHALL wait for tmr_running=1 then enter RUN; if tmr_running stays 0 for 4 cycles, return to LAUNCH and re-pulse.
REQ-019 In RUN, tmr_done=1 SHALL end the phase; the next phase's LAUNCH is the following cycle.
REQ-020 tmr_done or tmr_halfway outside RUN SHALL be ignored.
REQ-021 Transitions: IDLE -(edge)-> WINDUP -> ACTIVE -> RECOVER -> IDLE.
REQ-022 hitbox_en SHALL assert the cycle after tmr_halfway in ACTIVE/RUN and deassert the cycle after tmr_done (second half of the active window only).
REQ-023 combo_depth SHALL increment on each ACTIVE entry and clear on IDLE entry; attack_count SHALL increment on RECOVER -> IDLE.
REQ-024 Edges during WINDUP/RECOVER SHALL be ignored; an edge coincident with the cycle entering IDLE SHALL be ignored.

Reset
REQ-025 reset=0 SHALL asynchronously force phase=0, sub-step LAUNCH, tmr_start=0, tmr_fraction=0, hitbox_en=0, busy=0, combo_depth=0, attack_count=0, edge detector history=1 (no false edge after reset).
REQ-026 Reset mid-phase SHALL abandon the attack without a further tmr_start; timer state is not owned by this block.

Configuration
REQ-027 Macro ATTACK_COMBO_EN defined: an edge during ACTIVE sets combo_pending; on ACTIVE done, if pending and combo_depth < MAX_COMBO, go to ACTIVE (new LAUNCH) instead of RECOVER; pending clears on ACTIVE entry.
REQ-028 Macro undefined: edges during ACTIVE ignored; combo_depth is 1 while ACTIVE/RECOVER, 0 otherwise; port list unchanged.

Structure
REQ-029 Shared package SHALL hold phase encodings, sub-step encodings, and ack timeout constant 4.
REQ-030 Rising-edge detector SHALL be sub-module edge_detect_rise; the rest is one FSM module.

Verification (bench pairs the block with the fraction-second timer at CLOCK_FREQ=1200: fractions 4/6/3 -> 300/200/400 cycles)
REQ-031 Single press -> tmr_start pulses exactly 3 times, phase 1/2/3 durations 300/200/400 cycles plus handshake, attack_count=1.
REQ-032 ACTIVE phase -> hitbox_en high ~100 cycles, rising 1 cycle after tmr_halfway, low 1 cycle after tmr_done.
REQ-033 Held button / presses in WINDUP and RECOVER -> no extra attack; attack_count stays 1.
REQ-034 With ATTACK_COMBO_EN, 5 presses across ACTIVE phases -> combo_depth reaches 3, then RECOVER; without macro -> single ACTIVE.
REQ-035 Timer forced to ignore first start -> re-pulse after 4 cycles, sequence completes normally.
REQ-036 reset low mid-ACTIVE -> all outputs at reset values same cycle, no tmr_start until a new press.
